b32p_bus_arbiter: RTL and testbench

Two-port memory bus arbiter for the B32P CPU. It shares the single CPU-side memory bus between the pipeline's instruction-fetch port and its data-access port. Each access is sequenced as start, wait for done, then acknowledge. Ties are resolved round-robin, and a watchdog returns an error acknowledge when the bus never answers.

---
 rtl/b32p_bus_arbiter_pkg.sv | 41 ++++
 rtl/b32p_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_b32p_bus_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b32p_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// b32p_bus_pkg
// Shared definitions for the B32P memory bus arbiter and the blocks that talk
// to it (CPU pipeline, memory unit).
//   - state_t : arbiter sequencing states (IDLE=0, START=1, WAIT=2, RESP=3)
//   - owner_t : which CPU port owns a bus transaction (FETCH=0, DATA=1)
//   - B32P_ADDR_W / B32P_DATA_W : default bus widths
//   - pick_owner : round-robin choice between the two request lines
// ---------------------------------------------------------------------------
package b32p_bus_pkg;

    localparam int B32P_ADDR_W = 27;
    localparam int B32P_DATA_W = 32;

    // Watchdog counter width; TIMEOUT is limited to 1..255 so it never wraps.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    // Data wins when fetch is not asking, or when both ask and fetch owned
    // the previous transaction. Only meaningful when at least one req is high.
    function automatic owner_t pick_owner(input logic   f_req,
                                          input logic   d_req,
                                          input owner_t last_owner);
        if (d_req && (!f_req || last_owner == FETCH)) begin
            return DATA;
        end
        return FETCH;
    endfunction

endpackage

// File: rtl/b32p_bus_arbiter.sv
// ---------------------------------------------------------------------------
// b32p_bus_arbiter
// Shares the single CPU-side memory bus between the instruction-fetch port
// and the data-access port. Each access runs IDLE -> START -> WAIT -> RESP.
// Simultaneous requests alternate (round-robin on the last owner). A watchdog
// ends a WAIT that lasts too long with an error acknowledge.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   f_req, f_addr         fetch request / address
//   f_q, f_ack            fetch read data / one-cycle completion pulse
//   d_req, d_we, d_addr,  data request, write enable, address, write data
//   d_data
//   d_q, d_ack            data read data / one-cycle completion pulse
//   err                   valid with an ack; 1 = access timed out
//   bus_start             one-cycle pulse opening a bus transaction
//   bus_addr, bus_data,   registered transaction address / write data /
//   bus_we                write enable, held until the next grant
//   bus_q, bus_done       bus read data / completion, sampled only in WAIT
// ---------------------------------------------------------------------------
module b32p_bus_arbiter
    import b32p_bus_pkg::*;
#(
    parameter int ADDR_W  = B32P_ADDR_W,
    parameter int DATA_W  = B32P_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_q,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic [DATA_W-1:0] d_q,
    output logic              d_ack,
    output logic              err,
    output logic              bus_start,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t             state;
    state_t             state_next;
    owner_t             owner;
    owner_t             last_owner;
    owner_t             grant_owner;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  result;
    logic               result_err;
    logic               timed_out;

    assign grant_owner = pick_owner(f_req, d_req, last_owner);
    assign timed_out   = (cnt == TIMEOUT_CNT);

    // Both ports read the same result register; only the ack tells which
    // port the value belongs to.
    assign f_q = result;
    assign d_q = result;
    assign err = result_err;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (f_req || d_req) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (bus_done || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus_start = 1'b0;
        f_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state)
            START: bus_start = 1'b1;
            RESP: begin
                f_ack = (owner == FETCH);
                d_ack = (owner == DATA);
            end
            default: ;
        endcase
    end

    // Transaction registers, watchdog and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_addr   <= '0;
            bus_data   <= '0;
            bus_we     <= 1'b0;
            owner      <= FETCH;
            last_owner <= FETCH;
            cnt        <= '0;
            result     <= '0;
            result_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_req || d_req) begin
                        owner <= grant_owner;
                        if (grant_owner == DATA) begin
                            bus_addr <= d_addr;
                            bus_data <= d_data;
                            bus_we   <= d_we;
                        end else begin
                            // Fetches are always reads with no payload.
                            bus_addr <= f_addr;
                            bus_data <= '0;
                            bus_we   <= 1'b0;
                        end
                    end
                end
                START: cnt <= '0;
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as done.
                    if (bus_done) begin
                        result     <= bus_we ? '0 : bus_q;
                        result_err <= 1'b0;
                    end else if (timed_out) begin
                        result     <= '0;
                        result_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RESP: last_owner <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_b32p_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_b32p_bus_arbiter
// Scoreboard bench for the B32P bus arbiter. A cycle-level reference process
// predicts, from the request/bus input levels and the timing rules of the
// arbiter, every bus_start and every acknowledge (cycle, owner, values) and
// queues them; a monitor on the falling edge pops and compares whenever the
// DUT shows bus_start or an ack. Directed scenarios come first, then a long
// randomized run with random requesters, a random bus slave and random resets.
// ---------------------------------------------------------------------------
module tb_b32p_bus_arbiter;

    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_q;
    logic          f_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data;
    logic [DW-1:0] d_q;
    logic          d_ack;
    logic          err;
    logic          bus_start;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data;
    logic          bus_we;
    logic [DW-1:0] bus_q;
    logic          bus_done;

    always #5 clk = ~clk;

    b32p_bus_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_q      (f_q),
        .f_ack    (f_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_data   (d_data),
        .d_q      (d_q),
        .d_ack    (d_ack),
        .err      (err),
        .bus_start(bus_start),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .bus_we   (bus_we),
        .bus_q    (bus_q),
        .bus_done (bus_done)
    );

    // own: 1 = data port, 0 = fetch port
    typedef struct {
        int            cyc;
        bit            own;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
        logic [DW-1:0] q;
        logic          er;
    } txn_t;

    txn_t exp_start[$];
    txn_t exp_ack[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // ---------------- reference model ----------------
    // Timing rules: a request seen while the arbiter is free in cycle c gives
    // bus_start in c+1; done is honoured only in cycles start+1 .. start+TMO+1;
    // the ack follows one cycle after done (or after the last waiting cycle on
    // timeout); the arbiter is free again the cycle after the ack.
    initial begin : model
        bit            m_busy      = 1'b0;
        int            m_idle_from = 0;
        int            m_start     = 0;
        bit            m_last      = 1'b0;
        txn_t          m_t;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_busy      = 1'b0;
                m_idle_from = cyc + 1;
                m_last      = 1'b0;
                exp_start.delete();
                exp_ack.delete();
            end else if (m_busy) begin
                if (cyc > m_start) begin
                    if (bus_done) begin
                        m_t.cyc = cyc + 1;
                        m_t.q   = m_t.we ? '0 : bus_q;
                        m_t.er  = 1'b0;
                        exp_ack.push_back(m_t);
                        m_busy      = 1'b0;
                        m_idle_from = cyc + 2;
                    end else if (cyc == m_start + TMO + 1) begin
                        m_t.cyc = cyc + 1;
                        m_t.q   = '0;
                        m_t.er  = 1'b1;
                        exp_ack.push_back(m_t);
                        m_busy      = 1'b0;
                        m_idle_from = cyc + 2;
                    end
                end
            end else if (cyc >= m_idle_from && (f_req || d_req)) begin
                if (f_req && d_req) m_t.own = !m_last;
                else                m_t.own = d_req;
                m_last = m_t.own;
                if (m_t.own) begin
                    m_t.addr = d_addr;
                    m_t.data = d_data;
                    m_t.we   = d_we;
                end else begin
                    m_t.addr = f_addr;
                    m_t.data = '0;
                    m_t.we   = 1'b0;
                end
                m_t.q   = '0;
                m_t.er  = 1'b0;
                m_t.cyc = cyc + 1;
                m_start = cyc + 1;
                m_busy  = 1'b1;
                exp_start.push_back(m_t);
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_ctrl", 64'({f_ack, d_ack, err, bus_start, bus_we}), 64'(0));
                check("reset_data", 64'(f_q | d_q | bus_data), 64'(0));
                check("reset_addr", 64'(bus_addr), 64'(0));
            end else begin
                while (exp_start.size() > 0 && exp_start[0].cyc < cyc) begin
                    flag("bus_start_missing", "predicted bus_start did not appear");
                    void'(exp_start.pop_front());
                end
                while (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
                    flag("ack_missing", "predicted ack did not appear");
                    void'(exp_ack.pop_front());
                end
                if (bus_start) begin
                    if (exp_start.size() == 0) begin
                        check("bus_start_unexpected", 64'(bus_start), 64'(0));
                    end else begin
                        t = exp_start.pop_front();
                        check("start_cycle", 64'(cyc), 64'(t.cyc));
                        check("start_addr", 64'(bus_addr), 64'(t.addr));
                        check("start_data", 64'(bus_data), 64'(t.data));
                        check("start_we", 64'(bus_we), 64'(t.we));
                    end
                end
                if (f_ack || d_ack) begin
                    if (exp_ack.size() == 0) begin
                        check("ack_unexpected", 64'({f_ack, d_ack}), 64'(0));
                    end else begin
                        t = exp_ack.pop_front();
                        check("ack_cycle", 64'(cyc), 64'(t.cyc));
                        check("ack_port", 64'({f_ack, d_ack}), t.own ? 64'(1) : 64'(2));
                        check("ack_q", 64'(d_ack ? d_q : f_q), 64'(t.q));
                        check("ack_err", 64'(err), 64'(t.er));
                        check("ack_addr_hold", 64'(bus_addr), 64'(t.addr));
                        check("ack_data_hold", 64'({bus_we, bus_data}), 64'({t.we, t.data}));
                    end
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (reset && bus_start) begin
                s = cyc;
                return;
            end
        end
        flag("wait_start", "bus_start not seen within 100 cycles");
    endtask

    task automatic wait_ack(output int a, output bit own, output logic [DW-1:0] q, output logic e);
        a = -1; own = 1'b0; q = '0; e = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (reset && (f_ack || d_ack)) begin
                a = cyc; own = d_ack; q = d_ack ? d_q : f_q; e = err;
                return;
            end
        end
        flag("wait_ack", "ack not seen within 100 cycles");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        int            s;
        int            a;
        int            c;
        bit            own;
        logic [DW-1:0] q;
        logic          e;
        logic [3:0]    seq;
        int            thr;
        logic          fa;
        logic          da;

        reset = 1'b0; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_data = '0; bus_q = '0; bus_done = 1'b0;
        thr = 50;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Fetch only, done on the third WAIT cycle.
        f_req = 1'b1; f_addr = 27'h0000100;
        wait_start(s);
        tick(); tick(); tick();
        bus_done = 1'b1; bus_q = 32'hDEADBEEF;
        tick();
        bus_done = 1'b0;
        wait_ack(a, own, q, e);
        check("fetch_latency", 64'(a - s), 64'(4));
        check("fetch_q", 64'(q), 64'(32'hDEADBEEF));
        check("fetch_port", 64'(own), 64'(0));
        tick();
        f_req = 1'b0;
        tick();

        // Data write; bus_q must be ignored.
        d_req = 1'b1; d_we = 1'b1; d_addr = 27'h12; d_data = 32'hCAFE0001;
        wait_start(s);
        tick();
        bus_done = 1'b1; bus_q = 32'h55555555;
        tick();
        bus_done = 1'b0;
        wait_ack(a, own, q, e);
        check("write_q", 64'(q), 64'(0));
        check("write_err", 64'(e), 64'(0));
        tick();
        d_req = 1'b0; d_we = 1'b0;

        // Simultaneous requests from reset: D, F, D, F.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        f_req = 1'b1; f_addr = 27'h0000200;
        d_req = 1'b1; d_addr = 27'h0000300; d_data = 32'h0; d_we = 1'b0;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            wait_start(s);
            tick();
            bus_done = 1'b1; bus_q = 32'h1000 + 32'(i);
            tick();
            bus_done = 1'b0;
            wait_ack(a, own, q, e);
            seq = {seq[2:0], own};
        end
        check("rr_sequence", 64'(seq), 64'(4'b1010));
        tick();
        f_req = 1'b0; d_req = 1'b0;
        tick();

        // Timeout with no done, then a late done in IDLE.
        f_req = 1'b1; f_addr = 27'h7FFFFFF;
        wait_start(s);
        wait_ack(a, own, q, e);
        check("timeout_latency", 64'(a - s), 64'(TMO + 2));
        check("timeout_err", 64'(e), 64'(1));
        check("timeout_q", 64'(q), 64'(0));
        tick();
        f_req = 1'b0;
        tick();
        bus_done = 1'b1; bus_q = 32'hBAD0BAD0;
        tick();
        bus_done = 1'b0;
        repeat (5) tick();

        // Reset in the middle of WAIT, done arriving right after.
        d_req = 1'b1; d_we = 1'b0; d_addr = 27'h0ABCDEF;
        wait_start(s);
        tick(); tick();
        reset = 1'b0; d_req = 1'b0;
        tick();
        reset = 1'b1; bus_done = 1'b1; bus_q = 32'h0BADF00D;
        tick();
        bus_done = 1'b0;
        repeat (2) tick();
        f_req = 1'b1; f_addr = 27'h0000044;
        c = cyc;
        wait_start(s);
        check("post_reset_start", 64'(s - c), 64'(1));
        tick();
        bus_done = 1'b1; bus_q = 32'h00C0FFEE;
        tick();
        bus_done = 1'b0;
        wait_ack(a, own, q, e);
        tick();
        f_req = 1'b0;
        tick();

        // done only during START is ignored.
        f_req = 1'b1; f_addr = 27'h0000055;
        c = cyc;
        tick();
        bus_done = 1'b1; bus_q = 32'h11111111;
        tick();
        bus_done = 1'b0;
        tick(); tick();
        bus_done = 1'b1; bus_q = 32'h22222222;
        tick();
        bus_done = 1'b0;
        wait_ack(a, own, q, e);
        check("start_done_ignored", 64'(a - c), 64'(5));
        check("start_done_q", 64'(q), 64'(32'h22222222));
        tick();
        f_req = 1'b0;
        repeat (3) tick();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                case ($urandom_range(0, 3))
                    0:       thr = 3;
                    1:       thr = 20;
                    2:       thr = 60;
                    default: thr = 100;
                endcase
            end
            @(negedge clk);
            fa = f_ack;
            da = d_ack;
            tick();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0; f_req = 1'b0; d_req = 1'b0;
            end else begin
                if (f_req) begin
                    if (fa) begin
                        f_req  = $urandom_range(0, 1) == 1;
                        f_addr = AW'($urandom);
                    end else if ($urandom_range(0, 63) == 0) begin
                        f_req = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    f_req  = 1'b1;
                    f_addr = AW'($urandom);
                end
                if (d_req) begin
                    if (da) begin
                        d_req  = $urandom_range(0, 1) == 1;
                        d_addr = AW'($urandom); d_data = $urandom; d_we = $urandom_range(0, 1) == 1;
                    end else if ($urandom_range(0, 63) == 0) begin
                        d_req = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    d_req  = 1'b1;
                    d_addr = AW'($urandom); d_data = $urandom; d_we = $urandom_range(0, 1) == 1;
                end
            end
            bus_done = $urandom_range(0, 99) < thr;
            bus_q    = $urandom;
        end

        // Drain: no new requests; any transaction in flight completes or times out.
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0; bus_done = 1'b0;
        repeat (2 * TMO + 10) tick();
        check("drain_start_queue", 64'(exp_start.size()), 64'(0));
        check("drain_ack_queue", 64'(exp_ack.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
